interleave_fifo_reader: RTL and testbench
=========================================

# interleave_fifo_reader

Read-side collector for the interleaved synchronous FIFO. The write side distributes a single valid/ready stream across NUM_LANES independent register FIFO lanes in strict round-robin order (element k goes to lane k mod NUM_LANES). This block drains those lanes in the same round-robin order, rebuilding the original stream in order behind one registered output stage. It sits between the lane FIFOs' output ports and the downstream consumer.

## Interface
- DATA_WIDTH, 8, width of each data word
- NUM_LANES, 4, number of interleaved lanes (>= 2; power of two not required)
- LANE_DEPTH, 4, capacity of each lane FIFO, used only for count sizing
- LB_LANES (derived), $clog2(NUM_LANES)
- LB_DEPTH (derived), $clog2(LANE_DEPTH)
- COUNT_W (derived), $clog2(NUM_LANES*LANE_DEPTH + 2)

- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush, same effect as reset
- lane_data  in  NUM_LANES x DATA_WIDTH  head word of each lane
- lane_valid  in  NUM_LANES  lane non-empty
- lane_ready  out  NUM_LANES  pop strobe to each lane (one-hot or zero)
- lane_count  in  NUM_LANES x (LB_DEPTH+1)  occupancy of each lane
- out_data  out  DATA_WIDTH  registered output word
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream accepts
- rd_lane  out  LB_LANES  lane currently expected to supply the next word
- count  out  COUNT_W  total words held: sum(lane_count) + out_valid

## Operation
- State: rd_ptr (LB_LANES bits), out_valid_r, out_data_r.
- Load enable: load_en = !out_valid_r | out_ready.
- lane_ready[i] = (i == rd_ptr) & load_en. All other lanes see 0. lane_ready does not depend on lane_valid.
- A pop happens when lane_valid[rd_ptr] & lane_ready[rd_ptr]. On a pop, out_data_r <= lane_data[rd_ptr] and out_valid_r <= 1. rd_ptr advances: it wraps explicitly from NUM_LANES-1 to 0. It does not rely on modular overflow.
- If load_en is set and there is no pop, out_valid_r <= 0 (output consumed, nothing refills it). out_data_r holds its last value.
- If load_en is clear, all state holds.
- Order preservation: if the head lane rd_ptr is empty, the block stalls on it. It never skips to a non-empty lane, even when later lanes hold data.
- count is combinational: the zero-extended sum of all lane_count values plus out_valid_r. Width COUNT_W, so it never overflows.
- rd_lane = rd_ptr.
- Reset or clear (either one active at a clock edge): rd_ptr <= 0, out_valid_r <= 0, out_data_r <= 0. clear has priority over any pop in the same cycle. The lanes are cleared by their own clear; this block does not forward clear.

## Timing
- Reset values: out_valid 0, out_data 0, rd_lane 0, lane_ready = one-hot on lane 0 (load_en = 1 once out_valid is 0), count = sum of the lane counts.
- Latency: a word at the head of lane rd_ptr appears on out_data one cycle after the pop edge.
- Throughput: 1 word/cycle sustained while the head lanes are non-empty and out_ready = 1. A simultaneous consume and refill in one cycle gives no bubble.
- Handshake: once out_valid is 1, it stays 1 and out_data stays stable until out_ready = 1.
- Backpressure: with out_ready = 0 and out_valid = 1, all lane_ready are 0 in the same cycle (combinational path out_ready -> lane_ready).
- Wrap-around: after a pop from lane NUM_LANES-1, rd_lane = 0 on the next cycle.
- Reset or clear mid-stream: the word held in the output register is dropped, and the first word after release is taken from lane 0.

## Test plan
- Reset: rstn = 0 for 2 cycles, then release -> out_valid 0, out_data 0, rd_lane 0, lane_ready = 4'b0001.
- Ordered drain: lanes 0-3 preloaded {0,4}, {1,5}, {2,6}, {3,7}, out_ready = 1 -> out_data 0..7 on 8 consecutive cycles, no bubbles, rd_lane back to 0 at the end.
- Head-empty stall: lane 1 empty, lanes 2 and 3 full, rd_ptr = 1 -> no pop and lane_ready = 4'b0010 until lane 1 gets data 0x55; 0x55 is output next, then lane 2's head.
- Backpressure: out_ready held low 3 cycles with out_valid = 1 -> out_data stable, lane_ready = 0, count constant; on release, one word per cycle resumes.
- Clear mid-stream: 5 words popped, out_valid = 1, clear pulsed with out_ready = 1 -> next cycle out_valid 0, rd_lane 0, no pop in the clear cycle.
- Count: lane counts {4,4,4,4} with out_valid = 1 and NUM_LANES = 4, LANE_DEPTH = 4 -> count = 17, width 5 bits.

Source files
------------

// File: rtl/interleave_fifo_reader_if.sv
// ----------------------------------------------------------------------------
// interleave_fifo_reader_if
// Signal bundle between the lane FIFO read ports, the interleave reader and
// the downstream consumer.
//   lane_data  : head word of each lane             (lanes  -> reader)
//   lane_valid : lane non-empty                     (lanes  -> reader)
//   lane_count : occupancy of each lane             (lanes  -> reader)
//   lane_ready : pop strobe, one-hot or zero        (reader -> lanes)
//   out_data   : registered output word             (reader -> consumer)
//   out_valid  : output register holds a word       (reader -> consumer)
//   out_ready  : consumer accepts                   (consumer -> reader)
//   rd_lane    : lane expected to supply next word  (reader -> observer)
//   count      : total words held in lanes + output (reader -> observer)
// The slave modport is the reader's view; master is the surrounding side.
// ----------------------------------------------------------------------------
interface interleave_fifo_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int LANE_DEPTH = 4
);
    localparam int LB_LANES = $clog2(NUM_LANES);
    localparam int LB_DEPTH = $clog2(LANE_DEPTH);
    localparam int COUNT_W  = $clog2(NUM_LANES * LANE_DEPTH + 2);

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]                 lane_valid;
    logic [NUM_LANES-1:0]                 lane_ready;
    logic [NUM_LANES-1:0][LB_DEPTH:0]     lane_count;
    logic [DATA_WIDTH-1:0]                out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [LB_LANES-1:0]                  rd_lane;
    logic [COUNT_W-1:0]                   count;

    modport slave (
        input  lane_data, lane_valid, lane_count, out_ready,
        output lane_ready, out_data, out_valid, rd_lane, count
    );

    modport master (
        output lane_data, lane_valid, lane_count, out_ready,
        input  lane_ready, out_data, out_valid, rd_lane, count
    );
endinterface

// File: rtl/interleave_fifo_reader.sv
// ----------------------------------------------------------------------------
// interleave_fifo_reader
// Drains NUM_LANES lane FIFOs in strict round-robin order, rebuilding the
// original stream behind a single registered output stage.
// Ports:
//   clk     : clock, all state on rising edge
//   rstn    : synchronous active-low reset
//   i_clear : synchronous flush, same effect as reset, wins over a pop
//   bus     : lane read ports + output handshake (interleave_fifo_reader_if)
// ----------------------------------------------------------------------------
module interleave_fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 4,
    parameter int LANE_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clear,
    interleave_fifo_reader_if.slave  bus
);
    localparam int LB_LANES = $clog2(NUM_LANES);
    localparam int COUNT_W  = $clog2(NUM_LANES * LANE_DEPTH + 2);
    localparam logic [LB_LANES-1:0] LAST_LANE = LB_LANES'(NUM_LANES - 1);

    logic [LB_LANES-1:0]   r_rd_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_load_en;
    logic                  w_pop;
    logic [LB_LANES-1:0]   w_rd_ptr_nxt;
    logic [NUM_LANES-1:0]  w_lane_ready;
    logic [COUNT_W-1:0]    w_count;

    // Output register can take a word when empty or being drained this cycle.
    assign w_load_en = !r_out_valid | bus.out_ready;

    // Ready goes only to the head lane and ignores its valid, so the reader
    // stalls on an empty head lane instead of skipping ahead.
    always_comb begin
        w_lane_ready = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LB_LANES'(i) == r_rd_ptr) begin
                w_lane_ready[i] = w_load_en;
            end
        end
    end

    assign w_pop = bus.lane_valid[r_rd_ptr] & w_load_en;

    // Explicit wrap so non-power-of-two lane counts work.
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_LANE) ? '0 : r_rd_ptr + LB_LANES'(1);

    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_load_en) begin
            if (w_pop) begin
                r_out_data  <= bus.lane_data[r_rd_ptr];
                r_out_valid <= 1'b1;
                r_rd_ptr    <= w_rd_ptr_nxt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // COUNT_W is sized for every lane full plus the output word.
    always_comb begin
        w_count = COUNT_W'(r_out_valid);
        for (int i = 0; i < NUM_LANES; i++) begin
            w_count = w_count + COUNT_W'(bus.lane_count[i]);
        end
    end

    assign bus.lane_ready = w_lane_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.rd_lane    = r_rd_ptr;
    assign bus.count      = w_count;
endmodule

// File: tb/tb_interleave_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_interleave_fifo_reader
// Directed bench for interleave_fifo_reader. Four behavioral lane FIFOs
// (depth 4) feed the reader; each scenario task pushes words and compares
// the reader outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_interleave_fifo_reader;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    interleave_fifo_reader_if #(.DATA_WIDTH(8), .NUM_LANES(4), .LANE_DEPTH(4)) bus ();

    interleave_fifo_reader #(.DATA_WIDTH(8), .NUM_LANES(4), .LANE_DEPTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (clear),
        .bus     (bus)
    );

    // Behavioral lanes: pop on lane_ready & non-empty, push from push_v/push_d.
    logic [7:0] lane_mem [4][4];
    int         lane_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] push_v = 4'b0000;
    logic [7:0] push_d [4];

    always @(posedge clk) begin : lane_model
        logic [7:0] m [4][4];
        int         c [4];
        m = lane_mem;
        c = lane_cnt;
        for (int i = 0; i < 4; i++) begin
            if (!rstn || clear) begin
                c[i] = 0;
            end else begin
                if (bus.lane_ready[i] && c[i] > 0) begin
                    for (int j = 0; j < 3; j++) m[i][j] = m[i][j+1];
                    c[i] = c[i] - 1;
                end
                if (push_v[i] && c[i] < 4) begin
                    m[i][c[i]] = push_d[i];
                    c[i] = c[i] + 1;
                end
            end
        end
        lane_mem <= m;
        lane_cnt <= c;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.lane_data[i]  = lane_mem[i][0];
            bus.lane_valid[i] = (lane_cnt[i] != 0);
            bus.lane_count[i] = 3'(lane_cnt[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        push_v = 4'b0000;
    endtask

    task automatic push(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
        push_v    = v;
        push_d[0] = d0;
        push_d[1] = d1;
        push_d[2] = d2;
        push_d[3] = d3;
        step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear = 1'b0;
        bus.out_ready = 1'b1;
        push_v = 4'b0000;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
        checks++; if (bus.rd_lane !== 2'd0) begin failures++; $display("FAIL reset_rd_lane got=%0d exp=0", bus.rd_lane); end
        checks++; if (bus.lane_ready !== 4'b0001) begin failures++; $display("FAIL reset_lane_ready got=%b exp=0001", bus.lane_ready); end
        checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_ordered_drain();
        do_reset();
        push(4'b1111, 8'd0, 8'd1, 8'd2, 8'd3);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) push(4'b1111, 8'd4, 8'd5, 8'd6, 8'd7);
            else step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(k)) begin
                failures++; $display("FAIL drain_word%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_data, 8'(k));
            end
            checks++; if (bus.count !== 5'(8 - k)) begin
                failures++; $display("FAIL drain_count%0d got=%0d exp=%0d", k, bus.count, 8 - k);
            end
        end
        checks++; if (bus.rd_lane !== 2'd0) begin failures++; $display("FAIL drain_wrap got=%0d exp=0", bus.rd_lane); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_head_stall();
        do_reset();
        push(4'b1101, 8'hA0, 8'h00, 8'h20, 8'h30);
        push(4'b1100, 8'h00, 8'h00, 8'h21, 8'h31);
        checks++; if (bus.out_data !== 8'hA0 || bus.rd_lane !== 2'd1) begin
            failures++; $display("FAIL stall_first got=%h/%0d exp=a0/1", bus.out_data, bus.rd_lane);
        end
        push(4'b1100, 8'h00, 8'h00, 8'h22, 8'h32);
        push(4'b1100, 8'h00, 8'h00, 8'h23, 8'h33);
        checks++; if (bus.count !== 5'd8) begin failures++; $display("FAIL stall_count got=%0d exp=8", bus.count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.lane_ready !== 4'b0010 || bus.out_valid !== 1'b0 || bus.rd_lane !== 2'd1) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%b/%0d exp=0010/0/1", k, bus.lane_ready, bus.out_valid, bus.rd_lane);
            end
            step();
        end
        push(4'b0010, 8'h00, 8'h55, 8'h00, 8'h00);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_fill got=%b exp=0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55 || bus.rd_lane !== 2'd2) begin
            failures++; $display("FAIL stall_55 got=%b/%h/%0d exp=1/55/2", bus.out_valid, bus.out_data, bus.rd_lane);
        end
        step();
        checks++; if (bus.out_data !== 8'h20 || bus.rd_lane !== 2'd3) begin
            failures++; $display("FAIL stall_next got=%h/%0d exp=20/3", bus.out_data, bus.rd_lane);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        push(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        push(4'b1111, 8'h14, 8'h15, 8'h16, 8'h17);
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.lane_ready !== 4'b0000) begin failures++; $display("FAIL bp_comb_ready got=%b exp=0000", bus.lane_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 || bus.lane_ready !== 4'b0000
                          || bus.count !== 5'd8 || bus.rd_lane !== 2'd1) begin
                failures++; $display("FAIL bp_hold%0d got=%b/%h/%b/%0d/%0d exp=1/10/0000/8/1", k,
                                     bus.out_valid, bus.out_data, bus.lane_ready, bus.count, bus.rd_lane);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.lane_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", bus.lane_ready); end
        for (int k = 1; k < 8; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h10 + k)) begin
                failures++; $display("FAIL bp_resume%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_data, 8'(8'h10 + k));
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        push(4'b1111, 8'h40, 8'h41, 8'h42, 8'h43);
        push(4'b1111, 8'h44, 8'h45, 8'h46, 8'h47);
        for (int k = 0; k < 4; k++) step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h44 || bus.rd_lane !== 2'd1) begin
            failures++; $display("FAIL clr_pre got=%b/%h/%0d exp=1/44/1", bus.out_valid, bus.out_data, bus.rd_lane);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.rd_lane !== 2'd0 || bus.out_data !== 8'h00 || bus.count !== 5'd0) begin
            failures++; $display("FAIL clr_post got=%b/%0d/%h/%0d exp=0/0/00/0", bus.out_valid, bus.rd_lane, bus.out_data, bus.count);
        end
        push(4'b1111, 8'h90, 8'h91, 8'h92, 8'h93);
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h90 || bus.rd_lane !== 2'd1) begin
            failures++; $display("FAIL clr_restart got=%b/%h/%0d exp=1/90/1", bus.out_valid, bus.out_data, bus.rd_lane);
        end
    endtask

    task automatic test_count();
        do_reset();
        bus.out_ready = 1'b0;
        push(4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        push(4'b1111, 8'hC4, 8'hC5, 8'hC6, 8'hC7);
        push(4'b1111, 8'hC8, 8'hC9, 8'hCA, 8'hCB);
        push(4'b1111, 8'hCC, 8'hCD, 8'hCE, 8'hCF);
        push(4'b0001, 8'hD0, 8'h00, 8'h00, 8'h00);
        checks++; if (bus.count !== 5'd17 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0) begin
            failures++; $display("FAIL count_full got=%0d/%b/%h exp=17/1/c0", bus.count, bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.count !== 5'd16 || bus.out_data !== 8'hC1) begin
            failures++; $display("FAIL count_after got=%0d/%h exp=16/c1", bus.count, bus.out_data);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_ordered_drain();
        test_head_stall();
        test_backpressure();
        test_clear();
        test_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
